// File: rtl/fxp_dot_acc_pkg.sv
// fxp_dot_acc_pkg: shared types and constants for the fixed-point
// dot-product accumulator (state enum, default sizes, rounding helper).
package fxp_dot_acc_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        ROUND,
        HOLD
    } state_t;

    localparam int DEF_LEN        = 8;
    localparam int DEF_ACC_W      = 40;
    localparam int DEF_FRAC_SHIFT = 8;
    localparam int DEF_OUT_W      = 16;

    // Half an output LSB, expressed in accumulator fraction bits.
    function automatic logic [63:0] round_const(input int frac_shift);
        return 64'd1 << (frac_shift - 1);
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// fxp_round_sat: round-half-up and (optionally) saturate a wide
// accumulator down to OUT_W bits.
// Ports: i_acc (ACC_W) in; o_data (OUT_W) result; o_sat clamp flag.
// Macro FXP_DOT_ACC_SATURATE_EN: defined -> clamp to all-ones and
// flag; undefined -> wrap-around, o_sat tied low.
module fxp_round_sat
    import fxp_dot_acc_pkg::*;
#(
    parameter int ACC_W      = DEF_ACC_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int OUT_W      = DEF_OUT_W
) (
    input  logic [ACC_W-1:0] i_acc,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat
);

    localparam logic [ACC_W:0] RND =
        (ACC_W+1)'(round_const(FRAC_SHIFT));

    logic [ACC_W:0] w_sum;
    logic [ACC_W:0] w_r;

    // One extra bit so adding the rounding constant never wraps.
    assign w_sum = {1'b0, i_acc} + RND;
    assign w_r   = w_sum >> FRAC_SHIFT;

`ifdef FXP_DOT_ACC_SATURATE_EN
    logic w_ovf;

    assign w_ovf  = |w_r[ACC_W:OUT_W];
    assign o_data = w_ovf ? {OUT_W{1'b1}} : w_r[OUT_W-1:0];
    assign o_sat  = w_ovf;
`else
    logic [ACC_W-OUT_W:0] w_unused_hi;

    assign w_unused_hi = w_r[ACC_W:OUT_W];
    assign o_data      = w_r[OUT_W-1:0];
    assign o_sat       = 1'b0;
`endif

endmodule

// File: rtl/fxp_dot_accumulator.sv
// fxp_dot_accumulator: sums LEN UQ16.16 products, then rounds and
// saturates to UQ8.8 on a valid/ready output.
// Ports: clk, rst (async high); in_valid/in_ready/in_prod upstream;
// out_valid/out_ready/out_data/out_sat downstream.
// Saturation selected by FXP_DOT_ACC_SATURATE_EN in fxp_round_sat.
module fxp_dot_accumulator
    import fxp_dot_acc_pkg::*;
#(
    parameter int LEN        = DEF_LEN,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int OUT_W      = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_sat;
    logic             r_out_valid;

    logic [OUT_W-1:0] w_res;
    logic             w_sat;

    fxp_round_sat #(
        .ACC_W      (ACC_W),
        .FRAC_SHIFT (FRAC_SHIFT),
        .OUT_W      (OUT_W)
    ) u_round_sat (
        .i_acc  (r_acc),
        .o_data (w_res),
        .o_sat  (w_sat)
    );

    // Decoded from state only: no path from out_ready.
    assign in_ready  = (r_state == ACCUM);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ACCUM: begin
                    if (in_valid) begin
                        r_acc <= r_acc + ACC_W'(in_prod);
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_state <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    r_out_data  <= w_res;
                    r_out_sat   <= w_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule
